// File: rtl/button_conditioner_pkg.sv
// Shared constants for the button conditioner: channel count, default debounce
// length, status word field offsets and a small popcount helper.
package button_conditioner_pkg;

  localparam int N_BUTTONS               = 4;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 48000;  // 1 ms at 48 MHz
  localparam int CNT_W                   = 16;
  localparam int COUNT_W                 = 8;

  localparam int LEVEL_LSB = 0;
  localparam int FLAG_LSB  = 4;
  localparam int COUNT_LSB = 8;

  function automatic logic [COUNT_W-1:0] popcount(input logic [N_BUTTONS-1:0] v);
    logic [COUNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      n = n + {{(COUNT_W-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/button_conditioner_debounce.sv
// One button channel: invert and synchronize the raw active-low input, require
// DEBOUNCE_CYCLES consecutive differing samples before accepting a new level.
module button_debounce
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic ti_clk,
  input  logic rst_n,
  input  logic button_n,
  output logic stable,
  output logic press_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    stable_d = stable_q;
    pulse_d  = 1'b0;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
        pulse_d  = sync2_q;  // only the 0->1 acceptance is a press
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: reset is synchronous (sampled on the clock edge), and sequential state uses <= only.
  always_ff @(posedge ti_clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= ~button_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable      = stable_q;
  assign press_pulse = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Four debounced buttons with press pulses, sticky press flags and a wrapping
// press counter, packed into a registered 16-bit status word.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic        ti_clk,
  input  logic        rst_n,
  input  logic [3:0]  button,
  input  logic        clear,
  output logic [3:0]  press_pulse,
  output logic [15:0] status
);

  logic [N_BUTTONS-1:0] stable;
  logic [N_BUTTONS-1:0] pulse;
  logic [N_BUTTONS-1:0] flags_q, flags_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 clear_q, clear_prev_q;
  logic                 clr_evt;
  logic [15:0]          status_q, status_d;

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .ti_clk      (ti_clk),
      .rst_n       (rst_n),
      .button_n    (button[i]),
      .stable      (stable[i]),
      .press_pulse (pulse[i])
    );
  end

  assign clr_evt = clear_q & ~clear_prev_q;

  // Clear is applied first, then this cycle's presses, so a coincident press survives.
  always_comb begin
    flags_d  = (clr_evt ? '0 : flags_q) | pulse;
    count_d  = (clr_evt ? '0 : count_q) + popcount(pulse);
    status_d = '0;
    status_d[LEVEL_LSB +: N_BUTTONS] = stable;
    status_d[FLAG_LSB  +: N_BUTTONS] = flags_d;
    status_d[COUNT_LSB +: COUNT_W]   = count_d;
  end

  always_ff @(posedge ti_clk) begin
    if (!rst_n) begin
      clear_q      <= 1'b0;
      clear_prev_q <= 1'b0;
      flags_q      <= '0;
      count_q      <= '0;
      status_q     <= '0;
    end else begin
      clear_q      <= clear;
      clear_prev_q <= clear_q;
      flags_q      <= flags_d;
      count_q      <= count_d;
      status_q     <= status_d;
    end
  end

  assign press_pulse = pulse;
  assign status      = status_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with DEBOUNCE_CYCLES=4: expected
// pulses/status are queued per cycle as stimulus is driven, then compared.
module tb_button_conditioner;

  logic        ti_clk = 1'b0;
  logic        rst_n;
  logic [3:0]  button;
  logic        clear;
  logic [3:0]  press_pulse;
  logic [15:0] status;

  button_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .ti_clk      (ti_clk),
    .rst_n       (rst_n),
    .button      (button),
    .clear       (clear),
    .press_pulse (press_pulse),
    .status      (status)
  );

  always #5 ti_clk = ~ti_clk;

  typedef struct {
    int          cyc;
    string       tag;
    logic [3:0]  pulse;
    logic [15:0] status;
    bit          chk_status;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] m_cnt = '0;
  logic [3:0] m_flags = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int c, input string tag, input logic [3:0] p,
                      input logic [15:0] s, input bit chk_s);
    exp_t e;
    e.cyc = c; e.tag = tag; e.pulse = p; e.status = s; e.chk_status = chk_s;
    sb.push_back(e);
  endtask

  // Advance one edge, sample 1 ns later, compare every item due this cycle.
  task automatic tick();
    exp_t it;
    bit   seen;
    @(posedge ti_clk);
    #1;
    cyc++;
    seen = 1'b0;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      it = sb.pop_front();
      if (it.cyc < cyc) begin
        check({it.tag, "_missed"}, cyc, it.cyc);
      end else begin
        seen = 1'b1;
        check({it.tag, "_pulse"}, {28'd0, press_pulse}, {28'd0, it.pulse});
        if (it.chk_status) check({it.tag, "_status"}, {16'd0, status}, {16'd0, it.status});
      end
    end
    if (!seen && press_pulse !== 4'h0) check("stray_pulse", {28'd0, press_pulse}, 32'd0);
  endtask

  task automatic step_exp(input string tag, input logic [15:0] s);
    push(cyc + 1, tag, 4'h0, s, 1'b1);
    tick();
  endtask

  // Press the buttons in mask, hold until accepted, then release fully.
  task automatic press_release(input string tag, input logic [3:0] mask);
    button = ~mask;
    push(cyc + 6, {tag, "_press"}, mask, 16'h0, 1'b0);
    m_cnt   = m_cnt + 8'($countones(mask));
    m_flags = m_flags | mask;
    push(cyc + 7, {tag, "_held"}, 4'h0, {m_cnt, m_flags, mask}, 1'b1);
    repeat (8) tick();
    button = 4'hF;
    push(cyc + 7, {tag, "_rel"}, 4'h0, {m_cnt, m_flags, 4'h0}, 1'b1);
    repeat (8) tick();
  endtask

  initial begin
    rst_n  = 1'b0;
    button = 4'hF;
    clear  = 1'b0;

    // Reset values, including no X after the first reset edge
    step_exp("rst0", 16'h0000);
    step_exp("rst1", 16'h0000);
    rst_n = 1'b1;
    step_exp("idle0", 16'h0000);
    step_exp("idle1", 16'h0000);

    // Single press of button 0: pulse 6 cycles after edge, status 0x0111 next
    press_release("single", 4'h1);

    // Short glitches on button 1 never accepted
    rst_n = 1'b0;
    step_exp("rst_b", 16'h0000);
    rst_n = 1'b1;
    m_cnt = '0;
    m_flags = '0;
    for (int r = 0; r < 10; r++) begin
      button = 4'b1101;
      repeat (3) step_exp("glitch", 16'h0000);
      button = 4'hF;
      repeat (2) step_exp("glitch", 16'h0000);
    end
    repeat (6) step_exp("glitch_tail", 16'h0000);

    // Ramp counter to 254, then a 4-wide press wraps it to 2
    for (int r = 0; r < 63; r++) press_release("ramp", 4'hF);
    press_release("ramp2", 4'h3);
    press_release("wrap", 4'hF);

    // Counter to 5, then clear held high for 20 cycles
    press_release("pre_clr", 4'h7);
    clear = 1'b1;
    push(cyc + 1, "clr_before", 4'h0, 16'h05F0, 1'b1);
    push(cyc + 2, "clr_evt", 4'h0, 16'h0000, 1'b1);
    m_cnt = '0;
    m_flags = '0;
    tick();
    tick();
    press_release("clr_held", 4'h1);
    repeat (2) step_exp("clr_hold", 16'h0110);
    clear = 1'b0;
    repeat (3) step_exp("clr_fall", 16'h0110);

    // clr_evt coincides with press_pulse[2]: set wins
    button = 4'b1011;
    push(cyc + 6, "coinc_press", 4'h4, 16'h0, 1'b0);
    repeat (5) tick();
    clear = 1'b1;
    m_cnt = 8'd1;
    m_flags = 4'h4;
    push(cyc + 2, "coinc", 4'h0, 16'h0144, 1'b1);
    tick();
    tick();
    clear = 1'b0;
    button = 4'hF;
    push(cyc + 7, "coinc_rel", 4'h0, 16'h0140, 1'b1);
    repeat (8) tick();

    // Reset mid-debounce with button 0 held; press reported after reset
    button = 4'hE;
    repeat (4) tick();
    rst_n = 1'b0;
    push(cyc + 1, "rst_mid", 4'h0, 16'h0000, 1'b1);
    tick();
    rst_n = 1'b1;
    push(cyc + 6, "post_rst_press", 4'h1, 16'h0, 1'b0);
    push(cyc + 7, "post_rst_status", 4'h0, 16'h0111, 1'b1);
    repeat (8) tick();

    check("sb_drain", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 48000, is the number of consecutive stable synchronized samples required to accept a button change (1 ms at 48 MHz); legal range 2..65535.
REQ-002 ti_clk  input  1  host interface clock; the sole clock, and all logic is rising-edge.
REQ-003 rst_n  input  1  reset, synchronous to ti_clk and active-low.
REQ-004 button  input  4  raw asynchronous on-board buttons, active-low (0 = pressed).
REQ-005 clear  input  1  level from a WireIn bit; each rising edge clears sticky flags and the press counter.
REQ-006 press_pulse  output  4  one-cycle pulse per button on each debounced press.
REQ-007 status  output  16  WireOut word: [3:0] debounced level (1 = pressed), [7:4] sticky press flags, [15:8] press counter.

Function
REQ-008 Each button bit shall be inverted, then passed through a 2-flop synchronizer to give s[i].
REQ-009 Each channel shall hold stable[i] and a 16-bit counter cnt[i]; when s[i]==stable[i], cnt[i]<=0.
REQ-010 When s[i]!=stable[i] and cnt[i]<DEBOUNCE_CYCLES-1, cnt[i] shall increment.
REQ-011 When s[i]!=stable[i] and cnt[i]==DEBOUNCE_CYCLES-1, stable[i]<=s[i] and cnt[i]<=0.
REQ-012 A glitch shorter than DEBOUNCE_CYCLES cycles shall not change stable[i], and any return to the stable value restarts the count from 0.
REQ-013 Latency from a clean raw edge to a stable[i] change shall be exactly 2+DEBOUNCE_CYCLES cycles.
REQ-014 press_pulse[i] shall be 1 for exactly the one cycle after stable[i] goes 0->1, and shall not pulse on release.
REQ-015 Sticky flag[i] shall set on press_pulse[i] and hold until cleared.
REQ-016 The clear input shall be registered once, and clr_evt is the cycle in which the registered value is 1 and its previous value was 0.
REQ-017 A held-high clear shall generate only one clr_evt.
REQ-018 On clr_evt, all sticky flags and the press counter shall go to 0.
REQ-019 If press_pulse[i] and clr_evt coincide, flag[i] shall end at 1 and the counter at popcount(press_pulse), so the set wins.
REQ-020 The 8-bit press counter shall add popcount(press_pulse) each cycle, modulo 256 (wraps; 255+1=0, 254+4=2).
REQ-021 status shall be registered and shall reflect state one cycle after the internal update.
REQ-022 stable[3:0] shall drive status[3:0] directly, with no extra gating.

Reset
REQ-023 While rst_n==0 at a ti_clk edge, the synchronizers, stable, cnt, flags, counter, clear register, press_pulse and status shall all go to 0.
REQ-024 A reset asserted mid-debounce shall discard the partial count.
REQ-025 A button held through reset shall be reported as a new press 2+DEBOUNCE_CYCLES cycles after rst_n rises.
REQ-026 No output shall be X after the first reset edge.

Structure
REQ-027 A shared package shall hold N_BUTTONS=4, the default DEBOUNCE_CYCLES, and the status field offsets LEVEL_LSB=0, FLAG_LSB=4 and COUNT_LSB=8.
REQ-028 The sub-module button_debounce (synchronizer, counter, stable, press pulse for one channel, parameterized by DEBOUNCE_CYCLES) shall be instantiated N_BUTTONS times.
REQ-029 The top shall own the clear edge-detect, flags, popcount adder and status register.

Verification (DEBOUNCE_CYCLES=4 in simulation)
REQ-030 Scenario: after reset, drive button=4'b1110 held -> press_pulse=4'b0001 exactly 6 cycles after the edge, and status=16'h0111 one cycle later.
REQ-031 Scenario: button[1] low for 3 cycles then high, repeated 10 times -> no press_pulse, and status stays 16'h0000.
REQ-032 Scenario: all four buttons pressed in the same cycle, on a counter value of 254 -> counter reads 8'h02, flags are 4'hF, and status=16'h02FF.
REQ-033 Scenario: clear held high for 20 cycles over flags=4'hF and counter=5 -> flags and counter are 0 once, and a later press during the same high level is not cleared.
REQ-034 Scenario: clr_evt in the same cycle as press_pulse[2] -> flag[2]=1 and counter=1.
REQ-035 Scenario: rst_n low for 1 cycle while cnt[0]=2 with button[0] held -> all outputs are 0, and press_pulse[0] fires 6 cycles after rst_n rises.
